// File: rtl/reg_bank_pkg.sv
// Shared constants and types for the lab CPU register bank.
// Holds the default geometry, the special-register indices and the output-slot state type.
package reg_bank_pkg;

   localparam int DEF_WIDTH   = 8;
   localparam int DEF_ADDR_W  = 3;
   localparam int DEF_OUT_IDX = 1;
   localparam int DEF_CNT_IDX = 5;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } out_state_t;

endpackage

// File: rtl/reg_bank_out_slot.sv
// Output-slot register with a valid/ready handshake toward the output consumer.
// A write to a full slot that is not being drained is refused through wrStall_o.
module out_slot
   import reg_bank_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wrReq_i,
   input  logic [WIDTH-1:0] wrData_i,
   input  logic             outReady_i,
   output logic [WIDTH-1:0] dataOut_o,
   output logic             outValid_o,
   output logic             wrStall_o
);

   out_state_t       state_q;
   out_state_t       state_d;
   logic [WIDTH-1:0] dataOut_q;
   logic [WIDTH-1:0] dataOut_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= EMPTY;
         dataOut_q <= '0;
      end else begin
         state_q   <= state_d;
         dataOut_q <= dataOut_d;
      end
   end

   // A full slot only takes a new word on the same edge the consumer drains the old one.
   always_comb begin
      state_d   = state_q;
      dataOut_d = dataOut_q;
      wrStall_o = 1'b0;
      case (state_q)
         EMPTY: begin
            if (wrReq_i) begin
               state_d   = FULL;
               dataOut_d = wrData_i;
            end
         end
         FULL: begin
            if (wrReq_i && outReady_i) begin
               dataOut_d = wrData_i;
            end else if (wrReq_i) begin
               wrStall_o = 1'b1;
            end else if (outReady_i) begin
               state_d = EMPTY;
            end
         end
      endcase
   end

   assign dataOut_o  = dataOut_q;
   assign outValid_o = (state_q == FULL);

endmodule

// File: rtl/reg_bank.sv
// Register bank for the lab CPU: clocked writes, two async read ports, an output slot and a loop counter.
// Define REG_BANK_BYPASS_EN to forward an accepted write straight to a matching read port.
module reg_bank
   import reg_bank_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int OUT_IDX = DEF_OUT_IDX,
   parameter int CNT_IDX = DEF_CNT_IDX
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              REG_WR,
   input  logic [ADDR_W-1:0] REG_DEST,
   input  logic [WIDTH-1:0]  WRITE_DATA,
   input  logic [ADDR_W-1:0] REG1,
   input  logic [ADDR_W-1:0] REG2,
   output logic [WIDTH-1:0]  DATA_1,
   output logic [WIDTH-1:0]  DATA_2,
   input  logic              CNT_DEC,
   output logic              CNT_ZERO,
   output logic [WIDTH-1:0]  DATA_O,
   output logic              OUT_VALID,
   input  logic              OUT_READY,
   output logic              WR_STALL
);

   localparam int                DEPTH    = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] OUT_ADDR = ADDR_W'(OUT_IDX);
   localparam logic [ADDR_W-1:0] CNT_ADDR = ADDR_W'(CNT_IDX);

   logic [WIDTH-1:0] regFile_q [DEPTH];
   logic [WIDTH-1:0] regFile_d [DEPTH];
   logic             slotWrReq;
   logic             wrAccept;
   logic             cntWrite;
   logic [WIDTH-1:0] storedData1;
   logic [WIDTH-1:0] storedData2;

   assign slotWrReq = REG_WR && (REG_DEST == OUT_ADDR);
   assign wrAccept  = REG_WR && !WR_STALL;
   assign cntWrite  = wrAccept && (REG_DEST == CNT_ADDR);

   out_slot #(
      .WIDTH(WIDTH)
   ) u_outSlot (
      .clk       (CLK),
      .rst       (RESET),
      .wrReq_i   (slotWrReq),
      .wrData_i  (WRITE_DATA),
      .outReady_i(OUT_READY),
      .dataOut_o (DATA_O),
      .outValid_o(OUT_VALID),
      .wrStall_o (WR_STALL)
   );

   // A write to the counter beats a decrement in the same cycle; decrement saturates at zero.
   always_comb begin
      regFile_d = regFile_q;
      if (wrAccept) begin
         regFile_d[REG_DEST] = WRITE_DATA;
      end
      if (CNT_DEC && !cntWrite && (regFile_q[CNT_ADDR] != '0)) begin
         regFile_d[CNT_ADDR] = regFile_q[CNT_ADDR] - WIDTH'(1);
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         for (int i = 0; i < DEPTH; i++) begin
            regFile_q[i] <= '0;
         end
      end else begin
         regFile_q <= regFile_d;
      end
   end

   assign CNT_ZERO = (regFile_q[CNT_ADDR] == '0);

   // The output slot's live contents live in out_slot, so its index reads from there.
   assign storedData1 = (REG1 == OUT_ADDR) ? DATA_O : regFile_q[REG1];
   assign storedData2 = (REG2 == OUT_ADDR) ? DATA_O : regFile_q[REG2];

`ifdef REG_BANK_BYPASS_EN
   assign DATA_1 = (wrAccept && (REG1 == REG_DEST)) ? WRITE_DATA : storedData1;
   assign DATA_2 = (wrAccept && (REG2 == REG_DEST)) ? WRITE_DATA : storedData2;
`else
   assign DATA_1 = storedData1;
   assign DATA_2 = storedData2;
`endif

endmodule

// File: tb/tb_reg_bank.sv
// Scoreboard bench for reg_bank: stimulus pushes expected outputs from a behavioural model,
// a negedge monitor pops and compares them against the DUT.
module tb_reg_bank;

   localparam int W   = 8;
   localparam int AW  = 3;
   localparam int OUT = 1;
   localparam int CNT = 5;

   logic          CLK = 1'b0;
   logic          RESET = 1'b1;
   logic          REG_WR = 1'b0;
   logic [AW-1:0] REG_DEST = '0;
   logic [W-1:0]  WRITE_DATA = '0;
   logic [AW-1:0] REG1 = '0;
   logic [AW-1:0] REG2 = '0;
   logic [W-1:0]  DATA_1;
   logic [W-1:0]  DATA_2;
   logic          CNT_DEC = 1'b0;
   logic          CNT_ZERO;
   logic [W-1:0]  DATA_O;
   logic          OUT_VALID;
   logic          OUT_READY = 1'b0;
   logic          WR_STALL;

   logic          wRESET = 1'b1;
   logic          wREG_WR = 1'b0;
   logic [3:0]    wREG_DEST = '0;
   logic [15:0]   wWRITE_DATA = '0;
   logic [3:0]    wREG1 = '0;
   logic [3:0]    wREG2 = '0;
   logic [15:0]   wDATA_1;
   logic [15:0]   wDATA_2;
   logic          wCNT_ZERO;
   logic [15:0]   wDATA_O;
   logic          wOUT_VALID;
   logic          wWR_STALL;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [W-1:0] d1;
      logic [W-1:0] d2;
      logic [W-1:0] dout;
      logic         valid;
      logic         zero;
      logic         stall;
      string        tag;
   } exp_t;

   exp_t sbQ[$];

   int unsigned mMem [8];
   int unsigned mOut;
   bit          mFull;

   always #5 CLK = ~CLK;

   reg_bank #(.WIDTH(W), .ADDR_W(AW), .OUT_IDX(OUT), .CNT_IDX(CNT)) dut (
      .CLK(CLK), .RESET(RESET), .REG_WR(REG_WR), .REG_DEST(REG_DEST),
      .WRITE_DATA(WRITE_DATA), .REG1(REG1), .REG2(REG2), .DATA_1(DATA_1),
      .DATA_2(DATA_2), .CNT_DEC(CNT_DEC), .CNT_ZERO(CNT_ZERO), .DATA_O(DATA_O),
      .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .WR_STALL(WR_STALL)
   );

   reg_bank #(.WIDTH(16), .ADDR_W(4), .OUT_IDX(OUT), .CNT_IDX(CNT)) dutWide (
      .CLK(CLK), .RESET(wRESET), .REG_WR(wREG_WR), .REG_DEST(wREG_DEST),
      .WRITE_DATA(wWRITE_DATA), .REG1(wREG1), .REG2(wREG2), .DATA_1(wDATA_1),
      .DATA_2(wDATA_2), .CNT_DEC(1'b0), .CNT_ZERO(wCNT_ZERO), .DATA_O(wDATA_O),
      .OUT_VALID(wOUT_VALID), .OUT_READY(1'b0), .WR_STALL(wWR_STALL)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic bit modelStall();
      return REG_WR && (int'(REG_DEST) == OUT) && mFull && !OUT_READY;
   endfunction

   function automatic int unsigned modelRead(input int unsigned a);
      int unsigned v;
      v = (a == OUT) ? mOut : mMem[a];
`ifdef REG_BANK_BYPASS_EN
      if (REG_WR && !modelStall() && (a == int'(REG_DEST))) v = WRITE_DATA;
`endif
      return v;
   endfunction

   function automatic void modelReset();
      foreach (mMem[i]) mMem[i] = 0;
      mOut  = 0;
      mFull = 0;
   endfunction

   // Applies the rules of one clock edge to the model, using the inputs held during the cycle.
   function automatic void modelEdge();
      bit acc;
      bit cntWrite;
      if (RESET) return;
      acc      = REG_WR && !modelStall();
      cntWrite = acc && (int'(REG_DEST) == CNT);
      if (acc && int'(REG_DEST) == OUT) begin
         mOut  = WRITE_DATA;
         mFull = 1;
      end else if (mFull && OUT_READY) begin
         mFull = 0;
      end
      if (acc && int'(REG_DEST) != OUT) mMem[REG_DEST] = WRITE_DATA;
      if (CNT_DEC && !cntWrite && mMem[CNT] > 0) mMem[CNT] = mMem[CNT] - 1;
   endfunction

   task automatic applyStimulus(input bit rst, input bit wr, input int dest, input int wdata,
                                input int r1, input int r2, input bit dec, input bit ready,
                                input string tag);
      exp_t e;
      @(posedge CLK);
      modelEdge();
      #1;
      RESET      = rst;
      REG_WR     = wr;
      REG_DEST   = AW'(dest);
      WRITE_DATA = W'(wdata);
      REG1       = AW'(r1);
      REG2       = AW'(r2);
      CNT_DEC    = dec;
      OUT_READY  = ready;
      if (rst) modelReset();
      e.d1    = W'(modelRead(REG1));
      e.d2    = W'(modelRead(REG2));
      e.dout  = W'(mOut);
      e.valid = mFull;
      e.zero  = (mMem[CNT] == 0);
      e.stall = modelStall();
      e.tag   = tag;
      sbQ.push_back(e);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge CLK);
         if (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            checkOutput({e.tag, "_data1"}, 32'(DATA_1), 32'(e.d1));
            checkOutput({e.tag, "_data2"}, 32'(DATA_2), 32'(e.d2));
            checkOutput({e.tag, "_dataO"}, 32'(DATA_O), 32'(e.dout));
            checkOutput({e.tag, "_valid"}, 32'(OUT_VALID), 32'(e.valid));
            checkOutput({e.tag, "_zero"}, 32'(CNT_ZERO), 32'(e.zero));
            checkOutput({e.tag, "_stall"}, 32'(WR_STALL), 32'(e.stall));
         end
      end
   end

   initial begin : stimulus
      int dest;
      modelReset();
      $display("[TB] start");
      applyStimulus(1, 0, 0, 0, 2, CNT, 0, 0, "reset");
      applyStimulus(0, 0, 0, 0, 2, OUT, 0, 0, "idle");

      applyStimulus(0, 1, 2, 'hA5, 2, 3, 0, 0, "wr_same_cycle");
      applyStimulus(0, 0, 0, 0, 2, 2, 0, 0, "wr_after_edge");

      applyStimulus(0, 1, OUT, 'h11, OUT, 0, 0, 0, "slot_load");
      applyStimulus(0, 1, OUT, 'h22, OUT, 2, 0, 0, "slot_stall");
      applyStimulus(0, 1, OUT, 'h22, OUT, 2, 0, 0, "slot_hold");
      applyStimulus(0, 1, OUT, 'h22, OUT, 2, 0, 1, "slot_b2b");
      applyStimulus(0, 0, 0, 0, OUT, 2, 0, 0, "slot_full");
      applyStimulus(0, 0, 0, 0, OUT, 2, 0, 1, "slot_drain");
      applyStimulus(0, 0, 0, 0, OUT, 2, 0, 0, "slot_empty");

      applyStimulus(0, 1, CNT, 3, CNT, 0, 0, 0, "cnt_load");
      for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, CNT, 0, 1, 0, "cnt_dec");
      applyStimulus(0, 0, 0, 0, CNT, 0, 0, 0, "cnt_sat");
      applyStimulus(0, 1, CNT, 9, CNT, 0, 1, 0, "cnt_wr_wins");
      applyStimulus(0, 0, 0, 0, CNT, 0, 0, 0, "cnt_nine");

      applyStimulus(0, 1, CNT, 7, CNT, OUT, 0, 0, "pre_reset_cnt");
      applyStimulus(0, 1, OUT, 'h33, CNT, OUT, 0, 0, "pre_reset_out");
      applyStimulus(0, 0, 0, 0, CNT, OUT, 0, 0, "pre_reset_full");
      applyStimulus(1, 0, 0, 0, 2, CNT, 0, 0, "mid_reset");
      applyStimulus(0, 1, 4, 'h5C, 4, OUT, 0, 0, "post_reset_wr");
      applyStimulus(0, 0, 0, 0, 4, 2, 0, 0, "post_reset_rd");

      for (int i = 0; i < 400; i++) begin
         case ($urandom % 4)
            0:       dest = OUT;
            1:       dest = CNT;
            default: dest = int'($urandom % 8);
         endcase
         applyStimulus(($urandom % 80) == 0, $urandom % 2, dest, int'($urandom % 256),
                       int'($urandom % 8), int'($urandom % 8), ($urandom % 3) == 0,
                       $urandom % 2, "rand");
      end
      applyStimulus(0, 0, 0, 0, CNT, OUT, 0, 0, "final");

      for (int i = 0; i < 10 && sbQ.size() > 0; i++) @(negedge CLK);
      #1;
      if (sbQ.size() > 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", sbQ.size());
      end

      @(posedge CLK);
      #1;
      wRESET      = 1'b0;
      wREG_WR     = 1'b1;
      wREG_DEST   = 4'd15;
      wWRITE_DATA = 16'hBEEF;
      wREG2       = 4'd15;
      wREG1       = 4'd3;
      @(negedge CLK);
`ifdef REG_BANK_BYPASS_EN
      checkOutput("wide_same_cycle", 32'(wDATA_2), 32'hBEEF);
`else
      checkOutput("wide_same_cycle", 32'(wDATA_2), 32'h0);
`endif
      @(posedge CLK);
      #1;
      wREG_WR = 1'b0;
      @(negedge CLK);
      checkOutput("wide_reg15", 32'(wDATA_2), 32'hBEEF);
      checkOutput("wide_other", 32'(wDATA_1), 32'h0);
      checkOutput("wide_zero", 32'(wCNT_ZERO), 32'h1);
      checkOutput("wide_valid", 32'(wOUT_VALID), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/reg_bank.md
# reg_bank

Parametrised register bank for the lab CPU datapath; the next generation of the 8-bit register file. Every index is a real register, writes are clocked, and reads are asynchronous through two ports. One index is an output slot with a valid/ready handshake toward the output consumer. Another index is a loop counter with a decrement strobe and zero flag. Sits between the decoder/ALU write-back path and the ALU operand inputs.

## Interface
- WIDTH, 8, data width of every register
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W registers
- OUT_IDX, 1, index of the output-slot register
- CNT_IDX, 5, index of the loop-counter register (must differ from OUT_IDX)

- CLK  in  1  single clock; all state updates on rising edge
- RESET  in  1  asynchronous, active-high reset
- REG_WR  in  1  write enable
- REG_DEST  in  ADDR_W  write address
- WRITE_DATA  in  WIDTH  write data
- REG1  in  ADDR_W  read address, port 1
- REG2  in  ADDR_W  read address, port 2
- DATA_1  out  WIDTH  read data, port 1 (combinational)
- DATA_2  out  WIDTH  read data, port 2 (combinational)
- CNT_DEC  in  1  decrement loop counter
- CNT_ZERO  out  1  loop counter == 0
- DATA_O  out  WIDTH  output-slot data
- OUT_VALID  out  1  output slot holds unconsumed data
- OUT_READY  in  1  consumer accepts DATA_O
- WR_STALL  out  1  current write to OUT_IDX refused; issuer must hold it

## Operation
- Reset (async, any time): all DEPTH registers = 0, DATA_O = 0, OUT_VALID = 0, CNT_ZERO = 1, WR_STALL = 0. A pending output word is discarded.
- Write: on rising edge with REG_WR = 1 and WR_STALL = 0, reg[REG_DEST] <= WRITE_DATA. All indices are writable. No default/dropped cases.
- Read: DATA_n = reg[REGn]. Reading OUT_IDX returns the slot contents (DATA_O). Reading CNT_IDX returns the counter.
- Output slot FSM, states EMPTY (OUT_VALID = 0) and FULL (OUT_VALID = 1):
  - EMPTY + write to OUT_IDX -> FULL, DATA_O loaded.
  - FULL + OUT_READY + write to OUT_IDX -> FULL, DATA_O reloaded (back-to-back transfer).
  - FULL + OUT_READY, no write -> EMPTY, DATA_O holds its value.
  - FULL + !OUT_READY + write to OUT_IDX -> WR_STALL = 1 (combinational), write dropped, state stays FULL.
  - FULL + !OUT_READY, no write -> FULL.
- Loop counter:
  - CNT_DEC decrements by 1, saturating at 0; it never wraps to all-ones.
  - If a write to CNT_IDX and CNT_DEC occur in the same cycle, the write wins.
  - CNT_ZERO is decoded from the register, not from the next value.
- Arithmetic is unsigned WIDTH-bit. No other register has side effects.

## Timing
- Write latency is 1 edge. Read latency is 0, and reads return the pre-edge value unless bypass is enabled (see Configuration).
- OUT_VALID rises on the edge after an accepted OUT_IDX write.
- A transfer occurs on an edge where OUT_VALID and OUT_READY are both 1.
- WR_STALL = REG_WR & (REG_DEST == OUT_IDX) & OUT_VALID & !OUT_READY. It is the same cycle, with no registered state.
- CNT_ZERO updates one edge after the decrement or write that makes the counter zero.
- Reset deassertion: the first write is accepted on the first rising edge after RESET falls.

## Configuration
- REG_BANK_BYPASS_EN defined: when REG_WR = 1, WR_STALL = 0 and REGn == REG_DEST, DATA_n = WRITE_DATA in the same cycle. This gives write-to-read forwarding.
- REG_BANK_BYPASS_EN undefined: DATA_n shows the stored value; a new value is visible only after the edge.
- The counter-decrement result is never bypassed.

## Structure
- reg_bank_pkg: default WIDTH/ADDR_W constants, OUT_IDX/CNT_IDX defaults, and typedef enum out_state_t {EMPTY, FULL}.
- Sub-module out_slot: holds DATA_O, the EMPTY/FULL FSM and WR_STALL generation.
- Top level: storage array, read muxes, counter and bypass.

## Test plan
- Assert RESET mid-run with OUT_VALID = 1 and the counter = 7 -> immediately DATA_O = 0, OUT_VALID = 0, CNT_ZERO = 1, and all reads return 0.
- Write 0xA5 to reg 2, then read REG1 = 2 in the same cycle -> 0x00 without the macro, 0xA5 with REG_BANK_BYPASS_EN; both return 0xA5 after the edge.
- Write 0x11 to OUT_IDX with OUT_READY = 0 -> OUT_VALID = 1 next edge. Write 0x22 -> WR_STALL = 1 and DATA_O stays 0x11. Raise OUT_READY -> 0x22 is accepted and OUT_VALID stays 1.
- Write 3 to CNT_IDX, then pulse CNT_DEC 4 times -> 2, 1, 0, 0; CNT_ZERO = 1 after the third pulse, with no wrap.
- Write 9 to CNT_IDX with CNT_DEC = 1 in the same cycle -> counter = 9.
- With WIDTH = 16 and ADDR_W = 4, write 0xBEEF to reg 15 -> DATA_2 = 0xBEEF when REG2 = 15.
